equ_check_stream: RTL

Parametrised, clocked successor to the 2-bit equality checker. It compares two WIDTH-bit sample streams on each valid beat, under a selectable compare mode, and registers the result. It keeps saturating match/mismatch counters and records the beat index of the first mismatch. A lock FSM declares the streams aligned after RUN_LEN consecutive equal beats and raises a sticky alarm if a locked stream later mismatches. It sits on datapath outputs as a self-check monitor in benches and silicon.

---
 rtl/equ_check_stream.sv | 136 +++++++++++++
 1 files changed

// File: rtl/equ_check_stream.sv
// Streaming equality/magnitude self-check monitor with saturating statistics,
// first-mismatch capture and a lock/alarm FSM driven by consecutive equal beats.
module equ_check_stream #(
    parameter int WIDTH   = 8,
    parameter int CNT_W   = 16,
    parameter int RUN_LEN = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             valid,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [1:0]       mode,
    output logic             z,
    output logic             z_valid,
    output logic [CNT_W-1:0] match_cnt,
    output logic [CNT_W-1:0] mismatch_cnt,
    output logic             first_err,
    output logic [CNT_W-1:0] first_err_idx,
    output logic             locked,
    output logic             alarm
);

    // state  | meaning
    // HUNT   | counting consecutive equal beats toward RUN_LEN
    // LOCKED | streams aligned; next mismatch raises the alarm
    // ALARM  | a locked stream mismatched; held until clr or reset
    typedef enum logic [1:0] {HUNT, LOCKED, ALARM} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] RUN_TC  = CNT_W'(RUN_LEN);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] run_q, run_d;
    logic [CNT_W-1:0] beat_idx;
    logic             eq;
    logic             cmp;

    always_comb begin
        eq = (x == y);
        case (mode)
            2'b00:   cmp = eq;
            2'b01:   cmp = !eq;
            2'b10:   cmp = (x < y);
            default: cmp = (x > y);
        endcase
    end

    always_comb begin
        state_d = state_q;
        run_d   = run_q;
        if (valid) begin
            case (state_q)
                HUNT: begin
                    if (eq) begin
                        if (run_q != RUN_TC) begin
                            run_d = run_q + 1'b1;
                        end
                        if (run_d == RUN_TC) begin
                            state_d = LOCKED;
                        end
                    end else begin
                        run_d = '0;
                    end
                end
                LOCKED: begin
                    if (!eq) begin
                        state_d = ALARM;
                    end
                end
                ALARM:   state_d = ALARM;
                default: state_d = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= HUNT;
            run_q   <= '0;
        end else if (clr) begin
            state_q <= HUNT;
            run_q   <= '0;
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
        end
    end

    // clr wins over a coincident beat, so the datapath only advances when clr is low
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            z             <= 1'b0;
            z_valid       <= 1'b0;
            match_cnt     <= '0;
            mismatch_cnt  <= '0;
            first_err     <= 1'b0;
            first_err_idx <= '0;
            beat_idx      <= '0;
        end else if (clr) begin
            z             <= 1'b0;
            z_valid       <= 1'b0;
            match_cnt     <= '0;
            mismatch_cnt  <= '0;
            first_err     <= 1'b0;
            first_err_idx <= '0;
            beat_idx      <= '0;
        end else begin
            z_valid <= valid;
            if (valid) begin
                z <= cmp;
                if (beat_idx != CNT_MAX) begin
                    beat_idx <= beat_idx + 1'b1;
                end
                if (eq) begin
                    if (match_cnt != CNT_MAX) begin
                        match_cnt <= match_cnt + 1'b1;
                    end
                end else begin
                    if (mismatch_cnt != CNT_MAX) begin
                        mismatch_cnt <= mismatch_cnt + 1'b1;
                    end
                    if (!first_err) begin
                        first_err     <= 1'b1;
                        first_err_idx <= beat_idx;
                    end
                end
            end
        end
    end

    assign locked = (state_q == LOCKED);
    assign alarm  = (state_q == ALARM);

endmodule
